// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage of the vector ASIP. Owns the PC, presents it to the
//   combinational instruction ROM and captures the returned word into the IF/ID
//   pipeline register. Handles stall, flush, branch redirect, halt-word detection
//   and an out-of-range / misaligned fetch fault.
//
// Ports
//   clk            in   1   rising-edge clock
//   rst            in   1   synchronous active-high reset
//   PC             out  32  fetch address to instruction_memory
//   instruction    in   32  ROM word at PC (same cycle)
//   stall_f        in   1   hold PC and IF/ID
//   flush_d        in   1   turn IF/ID into a bubble
//   branch_taken   in   1   redirect request from execute
//   branch_target  in   32  redirect address
//   instr_d        out  32  IF/ID instruction (0 when invalid)
//   pc_d           out  32  IF/ID PC of instr_d
//   pc_plus4_d     out  32  IF/ID pc_d + 4
//   valid_d        out  1   IF/ID holds a real instruction
//   halted         out  1   stage is in HALT
//   fault          out  1   stage is in FAULT
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          IMEM_WORDS = 1024,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] PC,
  input  logic [31:0] instruction,
  input  logic        stall_f,
  input  logic        flush_d,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  output logic        halted,
  output logic        fault
);

  typedef enum logic [1:0] {
    RUN,
    HALT,
    FAULT
  } state_t;

  localparam logic [31:0] PC_LIMIT = 32'(4 * IMEM_WORDS);

  state_t      state;
  state_t      state_next;
  logic [31:0] pc_next;
  logic [31:0] pc_plus4;
  logic        is_halt_word;
  logic        load_word;

  function automatic logic is_legal(input logic [31:0] addr);
    return (addr[1:0] == 2'b00) && (addr < PC_LIMIT);
  endfunction

  // PC+4 is a plain modulo-2^32 add; a wrap past the ROM end is caught by
  // the range check rather than being allowed to roll over to address 0.
  assign pc_plus4     = PC + 32'd4;
  assign is_halt_word = (instruction == HALT_INSTR);

  // A fetched word only enters IF/ID while running and when it is not the
  // halt word; every other non-stalled cycle loads a bubble.
  assign load_word = (state == RUN) && !is_halt_word;

  // Next PC / next state. FAULT is sticky and ignores redirects. A redirect
  // beats the halt word fetched in the same cycle because that fetch was on
  // the wrong path, and a redirect out of HALT resumes fetching.
  always_comb begin
    state_next = state;
    pc_next    = PC;
    if (state == FAULT) begin
      state_next = FAULT;
    end else if (branch_taken) begin
      if (is_legal(branch_target)) begin
        pc_next    = branch_target;
        state_next = RUN;
      end else begin
        state_next = FAULT;
      end
    end else if (stall_f || (state != RUN)) begin
      state_next = state;
    end else if (is_halt_word) begin
      state_next = HALT;
    end else if (is_legal(pc_plus4)) begin
      pc_next = pc_plus4;
    end else begin
      state_next = FAULT;
    end
  end

  // State, PC and IF/ID registers. A bubble clears valid/instr but keeps the
  // old pc_d/pc_plus4_d so downstream debug still sees the last address.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      PC         <= RESET_PC;
      instr_d    <= 32'h0;
      pc_d       <= 32'h0;
      pc_plus4_d <= 32'h0;
      valid_d    <= 1'b0;
    end else begin
      state <= state_next;
      PC    <= pc_next;
      if (flush_d || branch_taken) begin
        instr_d <= 32'h0;
        valid_d <= 1'b0;
      end else if (!stall_f) begin
        if (load_word) begin
          instr_d    <= instruction;
          pc_d       <= PC;
          pc_plus4_d <= pc_plus4;
          valid_d    <= 1'b1;
        end else begin
          instr_d <= 32'h0;
          valid_d <= 1'b0;
        end
      end
    end
  end

  assign halted = (state == HALT);
  assign fault  = (state == FAULT);

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
//   Bench for fetch_stage. Runs directed vector tables (free running, stall,
//   branch, flush, fault, reset, halt, end-of-ROM) with hand-computed
//   expectations, then a randomized phase. Every cycle is also compared to a
//   behavioural model of the fetch stage kept in this file.
module tb_fetch_stage;

  localparam int          WORDS = 64;
  localparam logic [31:0] HALTW = 32'hFFFF_FFFF;
  localparam int          M_RUN = 0;
  localparam int          M_HALT = 1;
  localparam int          M_FAULT = 2;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        stall_f;
  logic        flush_d;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;
  logic        halted;
  logic        fault;

  logic [31:0] rom [WORDS];

  int total;
  int bad;

  // model state
  logic [31:0] m_pc;
  int          m_mode;
  logic [31:0] m_instr;
  logic [31:0] m_pcd;
  logic [31:0] m_pc4;
  logic        m_valid;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        flush;
    logic        br;
    logic [31:0] tgt;
    logic        use_exp;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic        exp_valid;
    logic        exp_halted;
    logic        exp_fault;
  } vec_t;

  vec_t vecs[$];

  fetch_stage #(
    .RESET_PC  (32'h0),
    .IMEM_WORDS(WORDS),
    .HALT_INSTR(HALTW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .PC           (pc),
    .instruction  (instruction),
    .stall_f      (stall_f),
    .flush_d      (flush_d),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .instr_d      (instr_d),
    .pc_d         (pc_d),
    .pc_plus4_d   (pc_plus4_d),
    .valid_d      (valid_d),
    .halted       (halted),
    .fault        (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] romRead(input logic [31:0] a);
    if (a < 32'(4 * WORDS)) return rom[int'(a >> 2)];
    return 32'h0;
  endfunction

  // Combinational ROM
  always_comb instruction = romRead(pc);

  function automatic bit mLegal(input logic [31:0] a);
    return (a % 4 == 0) && (longint'(a) < longint'(4 * WORDS));
  endfunction

  // Behavioural model: one clock edge of the fetch stage
  task automatic modelStep(input vec_t v);
    logic [31:0] word;
    word = romRead(m_pc);
    if (v.rst) begin
      m_pc = 0; m_mode = M_RUN; m_instr = 0; m_pcd = 0; m_pc4 = 0; m_valid = 0;
      return;
    end
    if (v.flush || v.br) begin
      m_instr = 0; m_valid = 0;
    end else if (!v.stall) begin
      if (m_mode == M_RUN && word != HALTW) begin
        m_instr = word; m_pcd = m_pc; m_pc4 = m_pc + 4; m_valid = 1;
      end else begin
        m_instr = 0; m_valid = 0;
      end
    end
    if (m_mode == M_FAULT) begin
      // stuck until reset
    end else if (v.br) begin
      if (mLegal(v.tgt)) begin m_pc = v.tgt; m_mode = M_RUN; end
      else m_mode = M_FAULT;
    end else if (v.stall || m_mode == M_HALT) begin
      // hold
    end else if (word == HALTW) begin
      m_mode = M_HALT;
    end else if (mLegal(m_pc + 4)) begin
      m_pc = m_pc + 4;
    end else begin
      m_mode = M_FAULT;
    end
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst = v.rst; stall_f = v.stall; flush_d = v.flush;
    branch_taken = v.br; branch_target = v.tgt;
    modelStep(v);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input vec_t v);
    cmp("model_pc",       pc,         m_pc);
    cmp("model_instr_d",  instr_d,    m_instr);
    cmp("model_pc_d",     pc_d,       m_pcd);
    cmp("model_pc4_d",    pc_plus4_d, m_pc4);
    cmp("model_valid_d",  {31'b0, valid_d}, {31'b0, m_valid});
    cmp("model_halted",   {31'b0, halted},  {31'b0, m_mode == M_HALT});
    cmp("model_fault",    {31'b0, fault},   {31'b0, m_mode == M_FAULT});
    if (v.use_exp) begin
      cmp("exp_pc",      pc,      v.exp_pc);
      cmp("exp_instr_d", instr_d, v.exp_instr);
      cmp("exp_valid_d", {31'b0, valid_d}, {31'b0, v.exp_valid});
      cmp("exp_halted",  {31'b0, halted},  {31'b0, v.exp_halted});
      cmp("exp_fault",   {31'b0, fault},   {31'b0, v.exp_fault});
      if (valid_d) cmp("exp_pc4_rel", pc_plus4_d, pc_d + 32'd4);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic s, input logic f, input logic b,
                              input logic [31:0] t, input logic [31:0] epc,
                              input logic [31:0] ein, input logic ev,
                              input logic eh, input logic ef);
    vec_t v;
    v.rst = r; v.stall = s; v.flush = f; v.br = b; v.tgt = t; v.use_exp = 1'b1;
    v.exp_pc = epc; v.exp_instr = ein; v.exp_valid = ev;
    v.exp_halted = eh; v.exp_fault = ef;
    return v;
  endfunction

  task automatic runVectors();
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i]);
    end
    vecs.delete();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t v;
    total = 0; bad = 0;
    rst = 1; stall_f = 0; flush_d = 0; branch_taken = 0; branch_target = 0;
    m_pc = 0; m_mode = M_RUN; m_instr = 0; m_pcd = 0; m_pc4 = 0; m_valid = 0;
    for (int i = 0; i < WORDS; i++) rom[i] = 32'(i + 1);

    // free run, stall, branch+stall, reset during stall, faults, flush
    //            rst s f b  tgt        pc         instr  v  h  f
    vecs.push_back(mk(1, 0, 0, 0, 0,        32'h0,  0,     0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,        32'h4,  1,     1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,        32'h8,  2,     1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,        32'h8,  2,     1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,        32'h8,  2,     1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,        32'hC,  3,     1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,        32'h10, 4,     1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 32'h40,   32'h40, 0,     0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,        32'h44, 32'h11, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,        32'h44, 32'h11, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0,        32'h0,  0,     0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h42,   32'h0,  0,     0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 32'h8,    32'h0,  0,     0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0,        32'h0,  0,     0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0,        32'h0,  0,     0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h100,  32'h0,  0,     0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0,        32'h0,  0,     0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,        32'h4,  1,     1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0,        32'h4,  0,     0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,        32'h8,  2,     1, 0, 0));
    runVectors();

    // end of ROM: PC+4 past the last word faults, last word still delivered
    vecs.push_back(mk(1, 0, 0, 0, 0,        32'h0,  0,     0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'hF8,   32'hF8, 0,     0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,        32'hFC, 63,    1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,        32'hFC, 64,    1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0,        32'hFC, 0,     0, 0, 1));
    runVectors();

    // halt word at PC=12, then redirect out of HALT
    rom[3] = HALTW;
    vecs.push_back(mk(1, 0, 0, 0, 0,        32'h0,  0,     0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,        32'h4,  1,     1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,        32'h8,  2,     1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,        32'hC,  3,     1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,        32'hC,  0,     0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,        32'hC,  0,     0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h0,    32'h0,  0,     0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,        32'h4,  1,     1, 0, 0));
    // redirect in the same cycle as the halt fetch wins
    vecs.push_back(mk(1, 0, 0, 0, 0,        32'h0,  0,     0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,        32'h4,  1,     1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,        32'h8,  2,     1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,        32'hC,  3,     1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h20,   32'h20, 0,     0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,        32'h24, 9,     1, 0, 0));
    runVectors();

    // randomized phase against the model only
    for (int i = 0; i < WORDS; i++)
      rom[i] = ($urandom_range(0, 11) == 0) ? HALTW : $urandom;
    v = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v.use_exp = 1'b0;
    applyStimulus(v);
    checkOutput(v);
    for (int n = 0; n < 600; n++) begin
      v.rst   = ($urandom_range(0, 49) == 0);
      v.stall = ($urandom_range(0, 4) == 0);
      v.flush = ($urandom_range(0, 5) == 0);
      v.br    = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 9))
        0:       v.tgt = $urandom;
        1:       v.tgt = 32'(4 * WORDS);
        default: v.tgt = {24'h0, 6'($urandom_range(0, WORDS - 1)), 2'b00};
      endcase
      applyStimulus(v);
      checkOutput(v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
